psr_unit: RTL and testbench
===========================

// Module: psr_unit
// PURPOSE
//  Processor Status Register stage directly downstream of the ARC ALU. Latches the ALU
//  {N,Z,V,C} flags on committed CC-updating ops and evaluates ARC branch conditions for
//  the control unit, with a registered decision. Also holds the trap-enable bit and a
//  saved PSR used for trap entry and return (rett).
// PARAMETERS
//  PSR_RESET  4'b0000  reset value of {N,Z,V,C}
//  ET_RESET   1'b1     reset value of trap-enable bit
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous active-low reset
//  alu_psr      in   4  ALU flags {N,Z,V,C}, combinational from the ALU this cycle
//  alu_func     in   4  ALU function code driving the ALU this cycle
//  cc_we        in   1  control unit commits the current ALU op this cycle
//  br_eval      in   1  pulse: evaluate the branch condition in cond
//  cond         in   4  ARC branch cond field, instr[28:25]
//  trap_req     in   1  pulse: trap entry
//  rett         in   1  pulse: return from trap
//  psr_q        out  4  current {N,Z,V,C}
//  et           out  1  trap enable
//  spsr_q       out  4  saved {N,Z,V,C}
//  br_valid     out  1  branch decision valid; one-cycle pulse
//  br_taken     out  1  branch decision; meaningful only while br_valid=1
//  err          out  1  sticky: double trap, or rett while not trapped
// BEHAVIOUR
//  Reset (async, rst_n=0): psr_q=PSR_RESET, et=ET_RESET, spsr_q=0, br_valid=0,
//   br_taken=0, err=0, state=RUN. Outputs hold reset values until the first clk edge
//   after release.
//  CC update, at clk edge, when cc_we=1 and no trap_req/rett is active:
//   - alu_func 0,1,2 (ANDCC/ORCC/NORCC): N,Z <= alu_psr[3:2]; V,C <= 0.
//   - alu_func 3 (ADDCC): {N,Z,V,C} <= alu_psr.
//   - alu_func 4..15: psr_q unchanged. cc_we is ignored for these codes.
//  Branch: br_eval=1 at edge k -> br_valid=1 and br_taken valid after edge k+1 (latency 1).
//   br_valid drops after the following edge unless br_eval is still asserted.
//   Flags used = psr_q as registered before edge k (see CONFIGURATION).
//   Cond mapping: 0001 be -> Z; 0101 bcs -> C; 0110 bneg -> N; 0111 bvs -> V;
//   1000 ba -> 1. All other codes -> 0 (not taken; br_valid still asserted).
//  FSM, states RUN and TRAPPED:
//   RUN, trap_req=1: spsr_q <= psr_q (pre-update value); et <= 0; go to TRAPPED.
//   TRAPPED, rett=1: psr_q <= spsr_q; et <= 1; go to RUN.
//   TRAPPED, trap_req=1: err <= 1; state, spsr_q and et unchanged.
//   RUN, rett=1: err <= 1; no other effect.
//  Simultaneous events:
//   - trap_req or rett with cc_we: CC update dropped (instruction squashed).
//   - trap_req and rett together: trap_req wins; rett ignored.
//   - br_eval with trap_req: br_valid stays 0 for that request.
//  err clears only on reset. Reset mid-trap returns the FSM to RUN with reset values.
// CONFIGURATION
//  PSR_FWD_EN defined:
//   br_eval with cc_we in the same cycle (CC op, no trap/rett) evaluates against the
//   flags being written, i.e. the forwarded value.
//  PSR_FWD_EN undefined:
//   Branch always evaluates the registered psr_q. The control unit must insert one
//   bubble between an ADDCC and a dependent branch.
// TESTING
//  1. Reset: rst_n=0 -> psr_q=0000, et=1, spsr_q=0, br_valid=0, err=0.
//  2. ADDCC: cc_we=1, func=3, alu_psr=0101 -> psr_q=0101.
//     Then ANDCC: func=0, alu_psr=1011 -> psr_q=1000.
//  3. psr_q=0100, br_eval, cond=0001 -> next cycle br_valid=1, br_taken=1.
//     cond=0101 -> br_taken=0. cond=0011 -> br_taken=0.
//  4. Same-cycle ADDCC alu_psr=0100 with br_eval cond=0001, psr_q=0000 ->
//     br_taken=1 with PSR_FWD_EN, br_taken=0 without.
//  5. psr_q=1001, trap_req -> spsr_q=1001, et=0. ADDCC 0010 -> psr_q=0010.
//     rett -> psr_q=1001, et=1.
//  6. Second trap_req while TRAPPED -> err=1, spsr_q kept. rett in RUN -> err=1.
//     cc_we with trap_req -> psr_q unchanged.

Source files
------------

// File: rtl/psr_unit.sv
// ============================================================================
// Module      : psr_unit
// Description : Processor status register behind the ARC ALU. It latches the
//               {N,Z,V,C} flags, holds the trap state and saved PSR, and
//               produces a registered branch decision.
//               Optional macro PSR_FWD_EN forwards same-cycle CC writes into
//               branch evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psr_unit #(
  parameter logic [3:0] PSR_RESET = 4'b0000,
  parameter logic       ET_RESET  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] alu_psr,
  input  logic [3:0] alu_func,
  input  logic       cc_we,
  input  logic       br_eval,
  input  logic [3:0] cond,
  input  logic       trap_req,
  input  logic       rett,
  output logic [3:0] psr_q,
  output logic       et,
  output logic [3:0] spsr_q,
  output logic       br_valid,
  output logic       br_taken,
  output logic       err
);

  localparam logic [3:0] FUNC_ADDCC = 4'd3;

  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    TRAPPED = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] psr_nxt;
  logic [3:0] spsr_nxt;
  logic       et_nxt;
  logic       err_nxt;
  logic       br_valid_nxt;
  logic       br_taken_nxt;

  logic       cc_func;
  logic [3:0] cc_val;
  logic       squash;
  logic       cc_commit;
  logic [3:0] br_flags;

  // Flag layout is {N,Z,V,C}
  function automatic logic cond_taken(input logic [3:0] c, input logic [3:0] f);
    logic t;
    t = 1'b0;
    case (c)
      COND_BE:   t = f[2];
      COND_BCS:  t = f[0];
      COND_BNEG: t = f[3];
      COND_BVS:  t = f[1];
      COND_BA:   t = 1'b1;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

  // Only ANDCC/ORCC/NORCC/ADDCC (codes 0..3) touch the flags.
  assign cc_func = (alu_func[3:2] == 2'b00);

  always_comb begin
    cc_val = {alu_psr[3:2], 2'b00};
    if (alu_func == FUNC_ADDCC) begin
      cc_val = alu_psr;
    end
  end

  // A trap or return squashes the instruction in the same slot.
  assign squash    = trap_req | rett;
  assign cc_commit = cc_we & cc_func & ~squash;

`ifdef PSR_FWD_EN
  assign br_flags = cc_commit ? cc_val : psr_q;
`else
  assign br_flags = psr_q;
`endif

  always_comb begin
    state_nxt = state;
    psr_nxt   = cc_commit ? cc_val : psr_q;
    spsr_nxt  = spsr_q;
    et_nxt    = et;
    err_nxt   = err;

    case (state)
      RUN: begin
        if (trap_req) begin
          spsr_nxt  = psr_q;
          et_nxt    = 1'b0;
          state_nxt = TRAPPED;
        end else if (rett) begin
          err_nxt = 1'b1;
        end
      end
      TRAPPED: begin
        if (trap_req) begin
          err_nxt = 1'b1;
        end else if (rett) begin
          psr_nxt   = spsr_q;
          et_nxt    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    br_valid_nxt = br_eval & ~trap_req;
    br_taken_nxt = br_valid_nxt & cond_taken(cond, br_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      psr_q    <= PSR_RESET;
      spsr_q   <= 4'b0000;
      et       <= ET_RESET;
      err      <= 1'b0;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      state    <= state_nxt;
      psr_q    <= psr_nxt;
      spsr_q   <= spsr_nxt;
      et       <= et_nxt;
      err      <= err_nxt;
      br_valid <= br_valid_nxt;
      br_taken <= br_taken_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psr_unit.sv
// ============================================================================
// Module      : tb_psr_unit
// Description : Directed vector bench for psr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psr_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] alu_psr;
  logic [3:0] alu_func;
  logic       cc_we;
  logic       br_eval;
  logic [3:0] cond;
  logic       trap_req;
  logic       rett;
  logic [3:0] psr_q;
  logic       et;
  logic [3:0] spsr_q;
  logic       br_valid;
  logic       br_taken;
  logic       err;

  int checks;
  int errors;

  psr_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_psr  (alu_psr),
    .alu_func (alu_func),
    .cc_we    (cc_we),
    .br_eval  (br_eval),
    .cond     (cond),
    .trap_req (trap_req),
    .rett     (rett),
    .psr_q    (psr_q),
    .et       (et),
    .spsr_q   (spsr_q),
    .br_valid (br_valid),
    .br_taken (br_taken),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cc_we;
    logic [3:0] func;
    logic [3:0] alu;
    logic       br_eval;
    logic [3:0] cond;
    logic       trap;
    logic       rett;
    logic [3:0] e_psr;
    logic       e_et;
    logic [3:0] e_spsr;
    logic       e_bv;
    logic       e_bt;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic [3:0] f, input logic [3:0] a,
                              input logic b, input logic [3:0] cd, input logic t,
                              input logic r, input logic [3:0] ep, input logic ee,
                              input logic [3:0] es, input logic ebv, input logic ebt,
                              input logic eerr);
    vec_t v;
    v.cc_we = c; v.func = f; v.alu = a; v.br_eval = b; v.cond = cd; v.trap = t;
    v.rett = r; v.e_psr = ep; v.e_et = ee; v.e_spsr = es; v.e_bv = ebv;
    v.e_bt = ebt; v.e_err = eerr;
    return v;
  endfunction

  task automatic idle_inputs();
    cc_we = 1'b0; alu_func = 4'd0; alu_psr = 4'd0; br_eval = 1'b0;
    cond = 4'd0; trap_req = 1'b0; rett = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [3:0] ep, input logic ee,
                             input logic [3:0] es, input logic ebv, input logic ebt,
                             input logic eerr);
    logic ok;
    ok = (psr_q === ep) && (et === ee) && (spsr_q === es) && (br_valid === ebv) &&
         (err === eerr) && (!ebv || (br_taken === ebt));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got psr=%b et=%b spsr=%b bv=%b bt=%b err=%b, want psr=%b et=%b spsr=%b bv=%b bt=%b err=%b",
               name, psr_q, et, spsr_q, br_valid, br_taken, err, ep, ee, es, ebv, ebt, eerr);
    end
  endtask

  // Drive one cycle of inputs at negedge, check outputs just after the edge.
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    cc_we = v.cc_we; alu_func = v.func; alu_psr = v.alu; br_eval = v.br_eval;
    cond = v.cond; trap_req = v.trap; rett = v.rett;
    @(posedge clk);
    #1;
    check_state(name, v.e_psr, v.e_et, v.e_spsr, v.e_bv, v.e_bt, v.e_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check_state("reset_async", 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_hold", 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic FWD_TAKEN =
`ifdef PSR_FWD_EN
    1'b1;
`else
    1'b0;
`endif

  vec_t vecs[$];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    idle_inputs();

    //            cc f     alu    be cond   tr rt   psr    et  spsr   bv bt  err
    vecs.push_back(mk(1, 4'd3, 4'b0101, 0, 4'b0000, 0, 0, 4'b0101, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'd0, 4'b1011, 0, 4'b0000, 0, 0, 4'b1000, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'd1, 4'b0111, 0, 4'b0000, 0, 0, 4'b0100, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'd5, 4'b1111, 0, 4'b0000, 0, 0, 4'b0100, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0001, 0, 0, 4'b0100, 1, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0101, 0, 0, 4'b0100, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0011, 0, 0, 4'b0100, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0100, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b1000, 0, 0, 4'b0100, 1, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(1, 4'd3, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 4'd3, 4'b0100, 1, 4'b0001, 0, 0, 4'b0100, 1, 4'b0000, 1, FWD_TAKEN, 0));
    vecs.push_back(mk(1, 4'd3, 4'b1001, 0, 4'b0000, 0, 0, 4'b1001, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0110, 0, 0, 4'b1001, 1, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0111, 0, 0, 4'b1001, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0101, 0, 0, 4'b1001, 1, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(1, 4'd3, 4'b0010, 1, 4'b1000, 1, 0, 4'b1001, 0, 4'b1001, 0, 0, 0));
    vecs.push_back(mk(1, 4'd3, 4'b0010, 0, 4'b0000, 0, 0, 4'b0010, 0, 4'b1001, 0, 0, 0));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0010, 0, 4'b1001, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 1, 4'b0111, 0, 0, 4'b0010, 0, 4'b1001, 1, 1, 1));
    vecs.push_back(mk(0, 4'd0, 4'b0000, 0, 4'b0000, 0, 1, 4'b1001, 1, 4'b1001, 0, 0, 1));
    vecs.push_back(mk(1, 4'd3, 4'b0011, 0, 4'b0000, 0, 1, 4'b1001, 1, 4'b1001, 0, 0, 1));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // trap_req and rett together in RUN: trap wins, no error raised.
    do_reset();
    step("addcc_pre",  mk(1, 4'd3, 4'b0110, 0, 4'b0000, 0, 0, 4'b0110, 1, 4'b0000, 0, 0, 0));
    step("trap_rett",  mk(0, 4'd0, 4'b0000, 0, 4'b0000, 1, 1, 4'b0110, 0, 4'b0110, 0, 0, 0));
    step("nor_trapd",  mk(1, 4'd2, 4'b1111, 0, 4'b0000, 0, 0, 4'b1100, 0, 4'b0110, 0, 0, 0));
    step("trap_rett2", mk(0, 4'd0, 4'b0000, 0, 4'b0000, 1, 1, 4'b1100, 0, 4'b0110, 0, 0, 1));

    // rett alone in RUN sets err and squashes the CC write.
    do_reset();
    step("addcc_pre2", mk(1, 4'd3, 4'b0001, 0, 4'b0000, 0, 0, 4'b0001, 1, 4'b0000, 0, 0, 0));
    step("rett_run",   mk(1, 4'd3, 4'b1110, 1, 4'b0101, 0, 1, 4'b0001, 1, 4'b0000, 1, 1, 1));
    step("err_sticky", mk(0, 4'd0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 1, 4'b0000, 0, 0, 1));

    // Reset while trapped returns to RUN: a following rett must flag err.
    step("trap_again", mk(0, 4'd0, 4'b0000, 0, 4'b0000, 1, 0, 4'b0001, 0, 4'b0001, 0, 0, 1));
    do_reset();
    step("rett_postrst", mk(0, 4'd0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0000, 1, 4'b0000, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
